// File: rtl/axi_ocp_pkg.sv
// Shared types for the AXI3 read-slave to OCP read-master bridge.
// Holds the OCP/AXI encodings, the FSM state type and the response mapping.
package axi_ocp_pkg;

    typedef enum logic [2:0] {
        OcpCmdIdle = 3'd0,
        OcpCmdWr   = 3'd1,
        OcpCmdRd   = 3'd2
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        OcpRespNull = 2'd0,
        OcpRespDva  = 2'd1,
        OcpRespFail = 2'd2,
        OcpRespErr  = 2'd3
    } ocp_resp_e;

    typedef enum logic [1:0] {
        AxiBurstFixed = 2'd0,
        AxiBurstIncr  = 2'd1,
        AxiBurstWrap  = 2'd2,
        AxiBurstRsvd  = 2'd3
    } axi_burst_e;

    typedef enum logic [1:0] {
        AxiRespOkay   = 2'd0,
        AxiRespExokay = 2'd1,
        AxiRespSlverr = 2'd2,
        AxiRespDecerr = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        RdIdle  = 2'd0,
        RdCmd   = 2'd1,
        RdDrain = 2'd2
    } rd_state_e;

    function automatic axi_resp_e ocp_to_axi_resp(input ocp_resp_e resp);
        axi_resp_e axi;
        case (resp)
            OcpRespFail: axi = AxiRespSlverr;
            OcpRespErr:  axi = AxiRespDecerr;
            default:     axi = AxiRespOkay;
        endcase
        return axi;
    endfunction

endpackage

// File: rtl/ocp_rsp_fifo.sv
// Registered synchronous FIFO buffering OCP read responses until the AXI R channel takes them.
// Push while full is accepted only together with a pop.
module ocp_rsp_fifo #(
    parameter int unsigned W     = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DepthLim = (PW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, rd_ptr_q;
    logic         wr_en, rd_en;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == DepthLim);
    assign empty_o = (count_o == '0);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_ocp_rd_bridge.sv
// AXI3 read slave to OCP read master: each AR burst becomes ARLEN+1 single-beat OCP reads,
// responses are buffered and returned as R beats. One burst in flight.
module axi_ocp_rd_bridge
    import axi_ocp_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    ARID,
    input  logic [AW-1:0] ARADDR,
    input  logic [3:0]    ARLEN,
    input  logic [2:0]    ARSIZE,
    input  logic [1:0]    ARBURST,
    input  logic          ARVALID,
    output logic          ARREADY,
    output logic [3:0]    RID,
    output logic [DW-1:0] RDATA,
    output logic [1:0]    RRESP,
    output logic          RLAST,
    output logic          RVALID,
    input  logic          RREADY,
    output logic [2:0]    MTagID,
    output logic [AW-1:0] MAddr,
    output logic [2:0]    MCmd,
    output logic [DW-1:0] Mdata,
    output logic          MDataValid,
    output logic          MRespAccept,
    input  logic          SCmdAccept,
    input  logic [DW-1:0] Sdata,
    input  logic          SDataAccept,
    input  logic [1:0]    SResp,
    output logic          spurious_rsp
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DepthLim = (CW+1)'(FIFO_DEPTH);

    rd_state_e     state_q, state_d;
    logic [3:0]    id_q, len_q, cmd_cnt_q, beat_cnt_q;
    logic [2:0]    size_q;
    axi_burst_e    burst_q;
    logic [AW-1:0] addr_q, addr_next, beat_bytes, wrap_mask;
    logic [CW-1:0] outst_q, outst_d, fifo_count;
    logic [CW:0]   inflight;
    logic          spur_q;

    logic          ar_hs, credit, cmd_rd, cmd_acc, last_cmd;
    logic          rsp_valid, push, pop, r_done, fifo_full, fifo_empty;
    ocp_resp_e     rsp;
    logic [1:0]    rsp_axi;
    logic          unused_sdataaccept;

    assign unused_sdataaccept = SDataAccept;

    assign ar_hs     = ARVALID && ARREADY;
    assign inflight  = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit    = (inflight < DepthLim);
    assign cmd_acc   = cmd_rd && SCmdAccept;
    assign last_cmd  = cmd_acc && (cmd_cnt_q == len_q);
    assign rsp       = ocp_resp_e'(SResp);
    assign rsp_valid = (rsp != OcpRespNull);
    // Only responses that match an issued command enter the buffer.
    assign push      = rsp_valid && MRespAccept && (outst_q != '0);
    assign pop       = RVALID && RREADY;
    assign r_done    = pop && RLAST;
    assign rsp_axi   = ocp_to_axi_resp(rsp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RdIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RdIdle:  if (ar_hs)    state_d = RdCmd;
            RdCmd:   if (last_cmd) state_d = RdDrain;
            RdDrain: if (r_done)   state_d = RdIdle;
            default: state_d = RdIdle;
        endcase
    end

    always_comb begin
        ARREADY = (state_q == RdIdle);
        cmd_rd  = (state_q == RdCmd) && credit;
        MCmd    = cmd_rd ? OcpCmdRd : OcpCmdIdle;
    end

    // WRAP window is (len+1) beats of 2^size bytes, aligned to its own size.
    always_comb begin
        beat_bytes = AW'(1) << size_q;
        wrap_mask  = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
        case (burst_q)
            AxiBurstIncr: addr_next = addr_q + beat_bytes;
            AxiBurstWrap: addr_next = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
            default:      addr_next = addr_q;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (cmd_acc && !push) begin
            outst_d = outst_q + CW'(1);
        end else if (!cmd_acc && push) begin
            outst_d = outst_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q       <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= AxiBurstFixed;
            addr_q     <= '0;
            cmd_cnt_q  <= '0;
            beat_cnt_q <= '0;
            outst_q    <= '0;
            spur_q     <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_q       <= ARID;
                len_q      <= ARLEN;
                size_q     <= ARSIZE;
                burst_q    <= axi_burst_e'(ARBURST);
                addr_q     <= ARADDR;
                cmd_cnt_q  <= '0;
                beat_cnt_q <= '0;
            end else begin
                if (cmd_acc) begin
                    addr_q    <= addr_next;
                    cmd_cnt_q <= cmd_cnt_q + 4'd1;
                end
                if (pop) begin
                    beat_cnt_q <= beat_cnt_q + 4'd1;
                end
            end
            outst_q <= outst_d;
            spur_q  <= rsp_valid && (outst_q == '0);
        end
    end

    ocp_rsp_fifo #(
        .W     (DW + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .wdata_i ({Sdata, rsp_axi}),
        .pop_i   (pop),
        .rdata_o ({RDATA, RRESP}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign RVALID       = !fifo_empty;
    assign RLAST        = RVALID && (beat_cnt_q == len_q);
    assign RID          = id_q;
    assign MTagID       = id_q[2:0];
    assign MAddr        = addr_q;
    assign Mdata        = '0;
    assign MDataValid   = 1'b0;
    assign MRespAccept  = !fifo_full;
    assign spurious_rsp = spur_q;

endmodule

// File: tb/tb_axi_ocp_rd_bridge.sv
// Directed bench for axi_ocp_rd_bridge: a simple in-order OCP target answers one cycle
// after each accepted command with data {response index, address[15:0]}.
module tb_axi_ocp_rd_bridge;

    logic        clk;
    logic        rst;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic [2:0]  MTagID;
    logic [31:0] MAddr;
    logic [2:0]  MCmd;
    logic [31:0] Mdata;
    logic        MDataValid, MRespAccept;
    logic        SCmdAccept;
    logic [31:0] Sdata;
    logic        SDataAccept;
    logic [1:0]  SResp;
    logic        spurious_rsp;

    axi_ocp_rd_bridge #(
        .AW         (32),
        .DW         (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ARID         (ARID),
        .ARADDR       (ARADDR),
        .ARLEN        (ARLEN),
        .ARSIZE       (ARSIZE),
        .ARBURST      (ARBURST),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .RID          (RID),
        .RDATA        (RDATA),
        .RRESP        (RRESP),
        .RLAST        (RLAST),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .MTagID       (MTagID),
        .MAddr        (MAddr),
        .MCmd         (MCmd),
        .Mdata        (Mdata),
        .MDataValid   (MDataValid),
        .MRespAccept  (MRespAccept),
        .SCmdAccept   (SCmdAccept),
        .Sdata        (Sdata),
        .SDataAccept  (SDataAccept),
        .SResp        (SResp),
        .spurious_rsp (spurious_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Target knobs written by the main thread, response state owned by the target process.
    logic [1:0]  rsp_code;
    int          spur_req;
    int          spur_done;
    int          resp_cnt;

    // Observations collected by the main thread.
    logic [31:0] acc_addr[$];
    logic [3:0]  r_id[$];
    logic [31:0] r_data[$];
    logic [1:0]  r_resp[$];
    logic        r_last[$];
    int          spur_seen;
    int          base;
    logic        ar_hs_seen;
    logic [31:0] exp_addr[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin : target
        logic        acc;
        logic [31:0] a;
        SResp     = 2'd0;
        Sdata     = '0;
        spur_done = 0;
        resp_cnt  = 0;
        forever begin
            @(negedge clk);
            acc = (MCmd == 3'd2) && SCmdAccept;
            a   = MAddr;
            @(posedge clk);
            #1;
            if (acc) begin
                SResp    = rsp_code;
                Sdata    = {resp_cnt[15:0], a[15:0]};
                resp_cnt = resp_cnt + 1;
            end else if (spur_req != spur_done) begin
                SResp     = 2'd1;
                Sdata     = 32'hFFFF_FFFF;
                spur_done = spur_req;
            end else begin
                SResp = 2'd0;
                Sdata = '0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        ar_hs_seen = ARVALID && ARREADY;
        if (MCmd == 3'd2 && SCmdAccept) acc_addr.push_back(MAddr);
        if (RVALID && RREADY) begin
            r_id.push_back(RID);
            r_data.push_back(RDATA);
            r_resp.push_back(RRESP);
            r_last.push_back(RLAST);
        end
        if (spurious_rsp) spur_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        int budget = 20;
        acc_addr.delete();
        r_id.delete();
        r_data.delete();
        r_resp.delete();
        r_last.delete();
        base    = resp_cnt;
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        ARSIZE  = size;
        ARBURST = burst;
        ARVALID = 1'b1;
        ar_hs_seen = 1'b0;
        while (!ar_hs_seen && budget > 0) begin
            tick();
            budget--;
        end
        ARVALID = 1'b0;
        if (!ar_hs_seen) check("ar_handshake_timeout", 64'(ar_hs_seen), 64'd1);
    endtask

    task automatic wait_beats(input string tag, input int n);
        int budget = 200;
        while (r_data.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        if (r_data.size() < n) check({tag, "_beat_timeout"}, 64'(r_data.size()), 64'(n));
    endtask

    task automatic check_burst(input string tag, input int n, input logic [3:0] id,
                               input logic [1:0] resp);
        check({tag, "_ncmd"}, 64'(acc_addr.size()), 64'(n));
        check({tag, "_nbeat"}, 64'(r_data.size()), 64'(n));
        for (int i = 0; i < n && i < acc_addr.size() && i < r_data.size(); i++) begin
            logic [31:0] ea;
            logic [31:0] ed;
            int          idx;
            ea  = exp_addr[i];
            idx = base + i;
            ed  = {idx[15:0], ea[15:0]};
            check($sformatf("%s_addr%0d", tag, i), 64'(acc_addr[i]), 64'(ea));
            check($sformatf("%s_rid%0d", tag, i), 64'(r_id[i]), 64'(id));
            check($sformatf("%s_data%0d", tag, i), 64'(r_data[i]), 64'(ed));
            check($sformatf("%s_resp%0d", tag, i), 64'(r_resp[i]), 64'(resp));
            check($sformatf("%s_last%0d", tag, i), 64'(r_last[i]), 64'(i == n - 1));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst         = 1'b0;
        ARVALID     = 1'b0;
        ARID        = '0;
        ARADDR      = '0;
        ARLEN       = '0;
        ARSIZE      = '0;
        ARBURST     = '0;
        RREADY      = 1'b0;
        SCmdAccept  = 1'b1;
        SDataAccept = 1'b0;
        rsp_code    = 2'd1;
        spur_req    = 0;
        spur_seen   = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values: {ARREADY,RVALID,RLAST,MCmd,MRespAccept,spurious_rsp,MDataValid}
        check("reset_ctrl", 64'({ARREADY, RVALID, RLAST, MCmd, MRespAccept, spurious_rsp, MDataValid}),
              64'(9'b1_0_0_000_1_0_0));
        check("reset_maddr", 64'({MTagID, MAddr}), 64'd0);
        check("reset_r", 64'({RID, RRESP, RDATA}), 64'd0);
        check("reset_mdata", 64'(Mdata), 64'd0);
        rst = 1'b1;
        tick();

        // INCR 0x100, 4 beats of 4 bytes
        RREADY = 1'b1;
        start_burst(4'd5, 32'h100, 4'd3, 3'd2, 2'd1);
        check("incr_first_cmd", 64'({MCmd, MTagID, MAddr}), {29'd0, 3'd2, 3'd5, 32'h100});
        check("incr_arready_busy", 64'(ARREADY), 64'd0);
        wait_beats("incr", 4);
        check("incr_arready_back", 64'(ARREADY), 64'd1);
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108; exp_addr[3] = 32'h10C;
        check_burst("incr", 4, 4'd5, 2'b00);
        tick();

        // WRAP 0x38 in a 16-byte window
        start_burst(4'd2, 32'h38, 4'd3, 3'd2, 2'd2);
        wait_beats("wrap", 4);
        exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
        check_burst("wrap", 4, 4'd2, 2'b00);
        tick();

        // FIXED 8 beats with R stalled: credit limits issue to the buffer depth
        RREADY = 1'b0;
        start_burst(4'd1, 32'h40, 4'd7, 3'd2, 2'd0);
        repeat (12) tick();
        check("fixed_stall_ncmd", 64'(acc_addr.size()), 64'd4);
        check("fixed_stall_mcmd", 64'(MCmd), 64'd0);
        check("fixed_stall_full", 64'({RVALID, MRespAccept}), 64'b10);
        RREADY = 1'b1;
        wait_beats("fixed", 8);
        for (int i = 0; i < 8; i++) exp_addr[i] = 32'h40;
        check_burst("fixed", 8, 4'd1, 2'b00);
        tick();
        check("fixed_arready_back", 64'(ARREADY), 64'd1);

        // Single-beat bursts with error responses
        rsp_code = 2'd3;
        start_burst(4'd3, 32'h200, 4'd0, 3'd2, 2'd1);
        wait_beats("err", 1);
        exp_addr[0] = 32'h200;
        check_burst("err", 1, 4'd3, 2'b11);
        check("err_arready_back", 64'(ARREADY), 64'd1);
        tick();
        rsp_code = 2'd2;
        start_burst(4'd11, 32'h204, 4'd0, 3'd2, 2'd1);
        wait_beats("fail", 1);
        exp_addr[0] = 32'h204;
        check_burst("fail", 1, 4'd11, 2'b10);
        tick();
        rsp_code = 2'd1;

        // Command held while the target refuses it
        SCmdAccept = 1'b0;
        start_burst(4'd4, 32'h80, 4'd1, 3'd2, 2'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold_cmd%0d", i), 64'({MCmd, MTagID, MAddr}), {29'd0, 3'd2, 3'd4, 32'h80});
            tick();
        end
        check("hold_no_accept", 64'(acc_addr.size()), 64'd0);
        SCmdAccept = 1'b1;
        wait_beats("hold", 2);
        exp_addr[0] = 32'h80; exp_addr[1] = 32'h84;
        check_burst("hold", 2, 4'd4, 2'b00);
        tick();

        // Unsolicited response while idle
        spur_seen = 0;
        spur_req  = spur_req + 1;
        repeat (5) tick();
        check("spurious_pulse", 64'(spur_seen), 64'd1);
        check("spurious_not_buffered", 64'(RVALID), 64'd0);

        // Reset in the middle of a burst, then a clean burst
        start_burst(4'd6, 32'h300, 4'd3, 3'd2, 2'd1);
        wait_beats("pre_rst", 1);
        rst = 1'b0;
        #1;
        check("midrst_ctrl", 64'({ARREADY, RVALID, RLAST, MCmd, MRespAccept, spurious_rsp}),
              64'(8'b1_0_0_000_1_0));
        check("midrst_maddr", 64'({MTagID, MAddr}), 64'd0);
        check("midrst_r", 64'({RID, RRESP, RDATA}), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        spur_seen = 0;
        start_burst(4'd7, 32'h500, 4'd1, 3'd2, 2'd1);
        wait_beats("post_rst", 2);
        exp_addr[0] = 32'h500; exp_addr[1] = 32'h504;
        check_burst("post_rst", 2, 4'd7, 2'b00);
        check("post_rst_no_spurious", 64'(spur_seen), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
